// File: rtl/gbdmg_vgm_pkg.sv
// gbdmg_vgm_pkg: shared definitions for the gbdmg VGM command player.
// Holds the VGM opcode constants, the fixed wait lengths, the player state
// enum and the opcode decoder used in the FETCH state.
package gbdmg_vgm_pkg;

  localparam logic [7:0] OP_GB_WRITE = 8'hB3;
  localparam logic [7:0] OP_WAIT_N   = 8'h61;
  localparam logic [7:0] OP_WAIT_735 = 8'h62;
  localparam logic [7:0] OP_WAIT_882 = 8'h63;
  localparam logic [7:0] OP_END      = 8'h66;

  localparam logic [15:0] WAIT_735 = 16'd735;
  localparam logic [15:0] WAIT_882 = 16'd882;

  typedef enum logic [2:0] {FETCH, OPERAND, WRITE, WAIT, DONE, ERROR} state_t;

  // Command class chosen from the opcode byte.
  typedef enum logic [2:0] {K_WRITE, K_WAIT16, K_WAIT, K_SKIP, K_END, K_BAD} kind_t;

  typedef struct packed {
    kind_t       kind;
    logic [2:0]  nops;  // operand bytes still to collect
    logic [15:0] n;     // immediate wait length (K_WAIT only)
  } dec_t;

  function automatic dec_t op_decode(input logic [7:0] op);
    dec_t d;
    d.kind = K_BAD;
    d.nops = 3'd0;
    d.n    = 16'd0;
    if (op == OP_GB_WRITE) begin
      d.kind = K_WRITE;  d.nops = 3'd2;
    end else if (op == OP_WAIT_N) begin
      d.kind = K_WAIT16; d.nops = 3'd2;
    end else if (op == OP_WAIT_735) begin
      d.kind = K_WAIT;   d.n = WAIT_735;
    end else if (op == OP_WAIT_882) begin
      d.kind = K_WAIT;   d.n = WAIT_882;
    end else if (op[7:4] == 4'h7) begin
      d.kind = K_WAIT;   d.n = {12'd0, op[3:0]} + 16'd1;
    end else if (op[7:4] == 4'h8) begin
      d.kind = K_WAIT;   d.n = {12'd0, op[3:0]};
    end else if (op == OP_END) begin
      d.kind = K_END;
    end else if (op[7:4] == 4'h3 || op == 8'h4F || op == 8'h50) begin
      d.kind = K_SKIP;   d.nops = 3'd1;
    end else if (op[7:4] == 4'h4 || op[7:4] == 4'h5 ||
                 op[7:4] == 4'hA || op[7:4] == 4'hB) begin
      // 0x4F, 0x50 and 0xB3 were claimed by earlier branches
      d.kind = K_SKIP;   d.nops = 3'd2;
    end else if (op[7:5] == 3'b110) begin
      d.kind = K_SKIP;   d.nops = 3'd3;
    end else if (op[7:5] == 3'b111) begin
      d.kind = K_SKIP;   d.nops = 3'd4;
    end else begin
      d.kind = K_BAD;
    end
    return d;
  endfunction

endpackage

// File: rtl/gbdmg_vgm_wait.sv
// gbdmg_vgm_wait: VGM wait timer (sample divider + sample counter).
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   load        load counter with n and restart the divider at SAMPLE_DIV-1
//   n           wait length in 44.1 kHz samples (must be nonzero when loaded)
//   run         advance the timer this cycle (0 freezes everything)
//   expire      high on the cycle whose tick takes the counter to zero
module gbdmg_vgm_wait #(
  parameter int SAMPLE_DIV = 567,
  parameter int WAIT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [WAIT_W-1:0] n,
  input  logic              run,
  output logic              expire
);

  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

  logic [DIV_W-1:0]  div;
  logic [WAIT_W-1:0] cnt;

  // Divider counts SAMPLE_DIV cycles per sample; each underflow consumes one sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= {DIV_W{1'b0}};
      cnt <= {WAIT_W{1'b0}};
    end else if (load) begin
      div <= DIV_LAST;
      cnt <= n;
    end else if (run) begin
      if (div == {DIV_W{1'b0}}) begin
        div <= DIV_LAST;
        if (cnt != {WAIT_W{1'b0}}) begin
          cnt <= cnt - WAIT_W'(1);
        end
      end else begin
        div <= div - DIV_W'(1);
      end
    end
  end

  assign expire = run && (div == {DIV_W{1'b0}}) && (cnt == WAIT_W'(1));

endmodule

// File: rtl/gbdmg_vgm_player.sv
// gbdmg_vgm_player: VGM byte-stream sequencer feeding the gbdmg APU.
// Accepts VGM command bytes over valid/ready, turns 0xB3 commands into
// single-cycle register writes and times wait commands in sample units.
// Ports:
//   in_clk, in_rst          clock, asynchronous active-low reset
//   in_data/in_valid/out_ready  byte stream handshake
//   in_run                  1 = play, 0 = pause
//   out_reg/out_val/out_wr  APU register write port
//   out_busy                high while waiting
//   out_done                end of stream reached (sticky)
//   out_err                 unsupported opcode seen (sticky)
//   out_loop                only with GBDMG_VGM_LOOP_EN: one-cycle pulse on 0x66
// Optional build macro: GBDMG_VGM_LOOP_EN (0x66 loops instead of stopping).
module gbdmg_vgm_player
  import gbdmg_vgm_pkg::*;
#(
  parameter int SAMPLE_DIV = 567,
  parameter int WAIT_W     = 16
) (
  input  logic       in_clk,
  input  logic       in_rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       out_ready,
  input  logic       in_run,
  output logic [5:0] out_reg,
  output logic [7:0] out_val,
  output logic       out_wr,
  output logic       out_busy,
  output logic       out_done,
  output logic       out_err
`ifdef GBDMG_VGM_LOOP_EN
  ,
  output logic       out_loop
`endif
);

  state_t            state;
  kind_t             kind;
  logic [2:0]        rem;
  logic [7:0]        prev;
  logic              accept;
  dec_t              dec;
  logic [15:0]       full;
  logic              wait_load;
  logic [WAIT_W-1:0] wait_n;
  logic              wait_run;
  logic              expire;

  assign out_ready = in_run && (state == FETCH || state == OPERAND);
  assign accept    = in_valid && out_ready;
  assign wait_run  = in_run && (state == WAIT);

  // Decode the incoming byte and decide whether the wait timer loads this cycle.
  always_comb begin
    dec       = op_decode(in_data);
    full      = {in_data, prev};  // little-endian 16-bit operand pair
    wait_load = 1'b0;
    wait_n    = {WAIT_W{1'b0}};
    if (accept && state == FETCH && dec.kind == K_WAIT && dec.n != 16'd0) begin
      wait_load = 1'b1;
      wait_n    = WAIT_W'(dec.n);
    end else if (accept && state == OPERAND && rem == 3'd1 &&
                 kind == K_WAIT16 && full != 16'd0) begin
      wait_load = 1'b1;
      wait_n    = WAIT_W'(full);
    end else begin
      wait_load = 1'b0;
      wait_n    = {WAIT_W{1'b0}};
    end
  end

  gbdmg_vgm_wait #(
    .SAMPLE_DIV(SAMPLE_DIV),
    .WAIT_W    (WAIT_W)
  ) u_wait (
    .clk   (in_clk),
    .rst_n (in_rst),
    .load  (wait_load),
    .n     (wait_n),
    .run   (wait_run),
    .expire(expire)
  );

  // Command FSM with registered APU write port and status flags.
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      state    <= FETCH;
      kind     <= K_SKIP;
      rem      <= 3'd0;
      prev     <= 8'h00;
      out_reg  <= 6'h00;
      out_val  <= 8'h00;
      out_wr   <= 1'b0;
      out_busy <= 1'b0;
      out_done <= 1'b0;
      out_err  <= 1'b0;
`ifdef GBDMG_VGM_LOOP_EN
      out_loop <= 1'b0;
`endif
    end else begin
      out_wr <= 1'b0;
`ifdef GBDMG_VGM_LOOP_EN
      out_loop <= 1'b0;
`endif
      case (state)
        FETCH: begin
          if (accept) begin
            kind <= dec.kind;
            rem  <= dec.nops;
            case (dec.kind)
              K_WRITE, K_WAIT16, K_SKIP: state <= OPERAND;
              K_WAIT: begin
                if (dec.n != 16'd0) begin
                  state    <= WAIT;
                  out_busy <= 1'b1;
                end else begin
                  state <= FETCH;
                end
              end
              K_END: begin
`ifdef GBDMG_VGM_LOOP_EN
                out_loop <= 1'b1;
                state    <= FETCH;
`else
                out_done <= 1'b1;
                state    <= DONE;
`endif
              end
              default: begin
                out_err <= 1'b1;
                state   <= ERROR;
              end
            endcase
          end
        end
        OPERAND: begin
          if (accept) begin
            prev <= in_data;
            rem  <= rem - 3'd1;
            if (rem == 3'd1) begin
              if (kind == K_WRITE) begin
                // Register indices beyond the APU map are dropped silently.
                if (prev < 8'h40) begin
                  out_reg <= prev[5:0];
                  out_val <= in_data;
                  out_wr  <= 1'b1;
                  state   <= WRITE;
                end else begin
                  state <= FETCH;
                end
              end else if (kind == K_WAIT16 && full != 16'd0) begin
                out_busy <= 1'b1;
                state    <= WAIT;
              end else begin
                state <= FETCH;
              end
            end
          end
        end
        WRITE: state <= FETCH;
        WAIT: begin
          if (expire) begin
            out_busy <= 1'b0;
            state    <= FETCH;
          end
        end
        DONE:  state <= DONE;
        ERROR: state <= ERROR;
        default: begin
          out_err <= 1'b1;
          state   <= ERROR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gbdmg_vgm_player.sv
// tb_gbdmg_vgm_player: scenario bench for gbdmg_vgm_player (SAMPLE_DIV=4).
// Expected APU writes are queued as stimulus is driven and popped when the
// DUT strobes out_wr; wait lengths are counted in out_busy cycles.
module tb_gbdmg_vgm_player;

  localparam int DIV = 4;

  logic       in_clk   = 1'b0;
  logic       in_rst   = 1'b0;
  logic [7:0] in_data  = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_run   = 1'b1;
  logic       out_ready;
  logic [5:0] out_reg;
  logic [7:0] out_val;
  logic       out_wr;
  logic       out_busy;
  logic       out_done;
  logic       out_err;
`ifdef GBDMG_VGM_LOOP_EN
  logic       out_loop;
`endif

  int          passed = 0;
  int          total  = 0;
  logic [13:0] exp_q[$];
  logic [7:0]  model[64];
  int          gap     = 0;
  bit          seen_wr = 1'b0;

  gbdmg_vgm_player #(.SAMPLE_DIV(DIV), .WAIT_W(16)) dut (
    .in_clk   (in_clk),
    .in_rst   (in_rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .out_ready(out_ready),
    .in_run   (in_run),
    .out_reg  (out_reg),
    .out_val  (out_val),
    .out_wr   (out_wr),
    .out_busy (out_busy),
    .out_done (out_done),
    .out_err  (out_err)
`ifdef GBDMG_VGM_LOOP_EN
    ,
    .out_loop (out_loop)
`endif
  );

  always #5 in_clk = ~in_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // Advance to the next falling edge and score any write strobe seen there.
  task automatic step();
    logic [13:0] e;
    @(negedge in_clk);
    if (out_wr === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL wr_unexpected: got reg=%h val=%h, required no write", out_reg, out_val);
      end else begin
        e = exp_q.pop_front();
        total++;
        if ({out_reg, out_val} !== e) $display("FAIL wr_data: got reg=%h val=%h, required reg=%h val=%h", out_reg, out_val, e[13:8], e[7:0]);
        else passed++;
      end
      if (seen_wr) begin
        total++;
        if (gap < 3) $display("FAIL wr_gap: got %0d low cycles, required >=3", gap);
        else passed++;
      end
      seen_wr = 1'b1;
      gap = 0;
      model[out_reg] = out_val;
    end else begin
      gap++;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k;
    in_data  = b;
    in_valid = 1'b1;
    k = 0;
    while (out_ready !== 1'b1 && k < 1000) begin
      step();
      k++;
    end
    if (out_ready !== 1'b1) begin
      total++;
      $display("FAIL send_timeout: byte %h not accepted, ready=%b required 1", b, out_ready);
    end else begin
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_run   = 1'b1;
    in_rst   = 1'b0;
    step();
    in_rst = 1'b1;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({out_reg, out_val, out_wr, out_busy, out_done, out_err, out_ready} !== {6'h00, 8'h00, 5'b00001})
      $display("FAIL reset_state: got reg=%h val=%h wr=%b busy=%b done=%b err=%b ready=%b, required 0/0/0/0/0/0/1",
               out_reg, out_val, out_wr, out_busy, out_done, out_err, out_ready);
    else passed++;
  endtask

  task automatic test_single_write();
    do_reset();
    exp_q.push_back({6'h12, 8'hF3});
    send_byte(8'hB3); send_byte(8'h12); send_byte(8'hF3);
    total++;
    if (out_wr !== 1'b1 || out_ready !== 1'b0) $display("FAIL single_strobe: got wr=%b ready=%b, required wr=1 ready=0", out_wr, out_ready);
    else passed++;
    step();
    total++;
    if (out_wr !== 1'b0 || out_ready !== 1'b1 || out_reg !== 6'h12 || out_val !== 8'hF3)
      $display("FAIL single_after: got wr=%b ready=%b reg=%h val=%h, required 0 1 12 f3", out_wr, out_ready, out_reg, out_val);
    else passed++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    exp_q.push_back({6'h01, 8'h80});
    exp_q.push_back({6'h04, 8'h87});
    send_byte(8'hB3); send_byte(8'h01); send_byte(8'h80);
    send_byte(8'hB3); send_byte(8'h04); send_byte(8'h87);
    repeat (4) step();
    total++;
    if (model[1] !== 8'h80 || model[4] !== 8'h87) $display("FAIL b2b_regs: got r1=%h r4=%h, required 80 87", model[1], model[4]);
    else passed++;
    total++;
    if (exp_q.size() != 0) $display("FAIL b2b_pending: got %0d writes missing, required 0", exp_q.size());
    else passed++;
  endtask

  // Send a 1- or 3-byte wait command and count the cycles out_busy stays high.
  task automatic run_wait(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                          input int nb, input int exp_busy, input string name);
    int n;
    do_reset();
    send_byte(b0);
    if (nb == 3) begin
      send_byte(b1);
      send_byte(b2);
    end
    n = 0;
    while (out_busy === 1'b1 && n < 5000) begin
      step();
      n++;
    end
    total++;
    if (n != exp_busy || out_ready !== 1'b1) $display("FAIL %s: got busy=%0d ready=%b, required busy=%0d ready=1", name, n, out_ready, exp_busy);
    else passed++;
  endtask

  task automatic test_wait();
    run_wait(8'h61, 8'h03, 8'h00, 3, 3 * DIV,   "wait_61_3");
    run_wait(8'h7F, 8'h00, 8'h00, 1, 16 * DIV,  "wait_7f");
    run_wait(8'h70, 8'h00, 8'h00, 1, 1 * DIV,   "wait_70");
    run_wait(8'h61, 8'h00, 8'h00, 3, 0,         "wait_61_0");
    run_wait(8'h80, 8'h00, 8'h00, 1, 0,         "wait_80");
    run_wait(8'h63, 8'h00, 8'h00, 1, 882 * DIV, "wait_63");
    run_wait(8'h61, 8'h00, 8'h01, 3, 256 * DIV, "wait_61_hi");
  endtask

  task automatic test_pause();
    int n;
    do_reset();
    send_byte(8'h62);
    n = 0;
    while (out_busy === 1'b1 && n < 5000) begin
      if (n == 100) in_run = 1'b0;
      if (n == 150) in_run = 1'b1;
      if (n == 120) begin
        total++;
        if (out_ready !== 1'b0) $display("FAIL pause_ready: got %b, required 0", out_ready);
        else passed++;
      end
      step();
      n++;
    end
    total++;
    if (n != 735 * DIV + 50) $display("FAIL pause_len: got %0d busy cycles, required %0d", n, 735 * DIV + 50);
    else passed++;
    in_run = 1'b0;
    #1;
    total++;
    if (out_ready !== 1'b0) $display("FAIL pause_fetch_ready: got %b, required 0", out_ready);
    else passed++;
    in_run = 1'b1;
  endtask

  task automatic test_skip_end();
    logic [7:0] bytes[$];
    do_reset();
    exp_q.push_back({6'h05, 8'hAA});
    bytes = '{8'h4F, 8'h55, 8'hC0, 8'h01, 8'h02, 8'h03, 8'hE0, 8'h01, 8'h02, 8'h03, 8'h04,
              8'h30, 8'h09, 8'hA0, 8'h01, 8'h02, 8'hB3, 8'h05, 8'hAA, 8'hB3, 8'h50, 8'h11, 8'h66};
    foreach (bytes[i]) send_byte(bytes[i]);
`ifdef GBDMG_VGM_LOOP_EN
    total++;
    if (out_loop !== 1'b1 || out_done !== 1'b0 || out_ready !== 1'b1)
      $display("FAIL end_loop: got loop=%b done=%b ready=%b, required 1 0 1", out_loop, out_done, out_ready);
    else passed++;
    step();
    total++;
    if (out_loop !== 1'b0) $display("FAIL end_loop_pulse: got %b, required 0", out_loop);
    else passed++;
`else
    total++;
    if (out_done !== 1'b1 || out_ready !== 1'b0 || out_err !== 1'b0)
      $display("FAIL end_done: got done=%b ready=%b err=%b, required 1 0 0", out_done, out_ready, out_err);
    else passed++;
    step();
    total++;
    if (out_done !== 1'b1 || out_ready !== 1'b0) $display("FAIL end_sticky: got done=%b ready=%b, required 1 0", out_done, out_ready);
    else passed++;
`endif
    total++;
    if (exp_q.size() != 0) $display("FAIL skip_pending: got %0d writes missing, required 0", exp_q.size());
    else passed++;
  endtask

  task automatic test_error();
    do_reset();
    in_data  = 8'h67;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    total++;
    if (out_err !== 1'b1 || out_ready !== 1'b0 || out_done !== 1'b0)
      $display("FAIL error_flag: got err=%b ready=%b done=%b, required 1 0 0", out_err, out_ready, out_done);
    else passed++;
    repeat (3) step();
    total++;
    if (out_err !== 1'b1 || out_ready !== 1'b0) $display("FAIL error_sticky: got err=%b ready=%b, required 1 0", out_err, out_ready);
    else passed++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_byte(8'hB3);
    send_byte(8'h07);
    in_rst = 1'b0;
    step();
    in_rst = 1'b1;
    total++;
    if ({out_wr, out_busy, out_err, out_ready} !== 4'b0001) $display("FAIL midreset_state: got wr=%b busy=%b err=%b ready=%b, required 0 0 0 1",
                                                                   out_wr, out_busy, out_err, out_ready);
    else passed++;
    exp_q.push_back({6'h02, 8'h33});
    send_byte(8'hB3); send_byte(8'h02); send_byte(8'h33);
    total++;
    if (out_wr !== 1'b1) $display("FAIL midreset_write: got wr=%b, required 1", out_wr);
    else passed++;
    #2 in_rst = 1'b0;
    #1;
    total++;
    if (out_wr !== 1'b0 || out_reg !== 6'h00 || out_val !== 8'h00)
      $display("FAIL async_reset: got wr=%b reg=%h val=%h, required 0 00 00", out_wr, out_reg, out_val);
    else passed++;
    step();
    in_rst = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_wait();
    test_pause();
    test_skip_end();
    test_error();
    test_reset_mid();
    total++;
    if (exp_q.size() != 0) $display("FAIL final_pending: got %0d writes missing, required 0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
